// File: rtl/nv_ctrl_pkg.sv
// Shared control definitions for the photon bin accumulator.
// Contents: sweep FSM state encoding and the default upstream count width.
package nv_ctrl_pkg;

    localparam int unsigned COUNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_GATE   = 2'd3
    } state_t;

endpackage

// File: rtl/photon_bin_accumulator_if.sv
// Result bus from the bin accumulator to its consumer (valid/ready).
// Signals:
//   out_valid  producer -> consumer  bin result held
//   out_ready  consumer -> producer  accept when out_valid & out_ready
//   out_sum    producer -> consumer  photon sum for the bin
//   out_bin    producer -> consumer  bin index of out_sum
//   out_sat    producer -> consumer  out_sum saturated
interface photon_bin_accumulator_if #(
    parameter int unsigned SUM_W     = 24,
    parameter int unsigned BIN_IDX_W = 4
);

    logic                 out_valid;
    logic                 out_ready;
    logic [SUM_W-1:0]     out_sum;
    logic [BIN_IDX_W-1:0] out_bin;
    logic                 out_sat;

    modport master (
        output out_valid,
        output out_sum,
        output out_bin,
        output out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_sum,
        input  out_bin,
        input  out_sat,
        output out_ready
    );

endinterface

// File: rtl/count_delta.sv
// Click increment extractor: remembers the previous count sample and returns
// the modulo-2^COUNT_W difference, so counter rollover is transparent.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr         force the remembered sample to 0 (upstream counter being cleared)
//   count_in    free-running click count
//   delta       count_in - previous sample, modulo 2^COUNT_W
module count_delta
    import nv_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic [COUNT_W-1:0] count_in,
    output logic [COUNT_W-1:0] delta
);

    logic [COUNT_W-1:0] r_prev;

    // Tracking outside the gate window is harmless: the sample is zeroed
    // on arm and the upstream counter reads 0 until gating begins.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_prev <= '0;
        end else begin
            r_prev <= count_in;
        end
    end

    assign delta = count_in - r_prev;

endmodule

// File: rtl/photon_bin_accumulator.sv
// Photon bin accumulator: one sweep of NUM_BINS gapless bins of BIN_CYCLES
// clocks each, summing click increments into saturating per-bin sums.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   start          begin a sweep (only honoured in IDLE)
//   count_in       upstream free-running click count
//   counter_reset  registered clear for the upstream counter
//   busy           sweep in progress (ARM through last GATE cycle)
//   done           one-cycle pulse when the last bin result is captured
//   overrun        sticky: a bin result was dropped under backpressure
//   out_if         result bus (valid/ready, sum, bin index, saturation flag)
module photon_bin_accumulator
    import nv_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W    = COUNT_W_DEF,
    parameter int unsigned SUM_W      = 24,
    parameter int unsigned BIN_CYCLES = 1000,
    parameter int unsigned NUM_BINS   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [COUNT_W-1:0]         count_in,
    output logic                       counter_reset,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    photon_bin_accumulator_if.master   out_if
);

    localparam int unsigned BIN_IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int unsigned CYC_W     = $clog2(BIN_CYCLES);
    localparam int unsigned EXT_W     = ((SUM_W > COUNT_W) ? SUM_W : COUNT_W) + 1;

    localparam logic [CYC_W-1:0]     CYC_LAST = CYC_W'(BIN_CYCLES - 1);
    localparam logic [BIN_IDX_W-1:0] BIN_LAST = BIN_IDX_W'(NUM_BINS - 1);
    localparam logic [EXT_W-1:0]     SUM_MAX  = {{(EXT_W - SUM_W){1'b0}}, {SUM_W{1'b1}}};

    state_t               r_state;
    logic                 r_counter_reset;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;
    logic [SUM_W-1:0]     r_acc;
    logic                 r_sat;
    logic [CYC_W-1:0]     r_cyc;
    logic [BIN_IDX_W-1:0] r_bin;
    logic                 r_out_valid;
    logic [SUM_W-1:0]     r_out_sum;
    logic [BIN_IDX_W-1:0] r_out_bin;
    logic                 r_out_sat;

    logic [COUNT_W-1:0]   w_delta;
    logic [EXT_W-1:0]     w_sum_ext;
    logic                 w_clamp;
    logic [SUM_W-1:0]     w_sat_sum;
    logic                 w_sat_next;
    logic                 w_bin_end;
    logic                 w_hs;
    logic                 w_clr_prev;

    assign w_clr_prev = (r_state == ST_ARM);

    count_delta #(
        .COUNT_W (COUNT_W)
    ) u_count_delta (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_clr_prev),
        .count_in (count_in),
        .delta    (w_delta)
    );

    // Saturating add evaluated one bit wider than either operand so the
    // clamp decision never sees a wrapped value.
    always_comb begin
        w_sum_ext  = EXT_W'(r_acc) + EXT_W'(w_delta);
        w_clamp    = (w_sum_ext > SUM_MAX);
        w_sat_sum  = w_clamp ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
        w_sat_next = r_sat | w_clamp;
    end

    assign w_bin_end = (r_cyc == CYC_LAST);
    assign w_hs      = r_out_valid & out_if.out_ready;

    // Sweep FSM, bin counters, accumulator and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_counter_reset <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_overrun       <= 1'b0;
            r_acc           <= '0;
            r_sat           <= 1'b0;
            r_cyc           <= '0;
            r_bin           <= '0;
            r_out_valid     <= 1'b0;
            r_out_sum       <= '0;
            r_out_bin       <= '0;
            r_out_sat       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_hs) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_counter_reset <= 1'b0;
                    if (start) begin
                        r_state         <= ST_ARM;
                        r_counter_reset <= 1'b1;
                        r_busy          <= 1'b1;
                        r_overrun       <= 1'b0;
                    end
                end

                ST_ARM: begin
                    r_counter_reset <= 1'b0;
                    r_state         <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    r_acc   <= '0;
                    r_sat   <= 1'b0;
                    r_cyc   <= '0;
                    r_bin   <= '0;
                    r_state <= ST_GATE;
                end

                ST_GATE: begin
                    if (w_bin_end) begin
                        // Restart immediately so the next bin has no dead cycle.
                        r_acc <= '0;
                        r_sat <= 1'b0;
                        r_cyc <= '0;
                        // A slot is free if empty or being drained this same edge.
                        if (!r_out_valid || w_hs) begin
                            r_out_valid <= 1'b1;
                            r_out_sum   <= w_sat_sum;
                            r_out_bin   <= r_bin;
                            r_out_sat   <= w_sat_next;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                        if (r_bin == BIN_LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_bin <= r_bin + BIN_IDX_W'(1);
                        end
                    end else begin
                        r_acc <= w_sat_sum;
                        r_sat <= w_sat_next;
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign counter_reset    = r_counter_reset;
    assign busy             = r_busy;
    assign done             = r_done;
    assign overrun          = r_overrun;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_sum   = r_out_sum;
    assign out_if.out_bin   = r_out_bin;
    assign out_if.out_sat   = r_out_sat;

endmodule

// File: tb/tb_photon_bin_accumulator.sv
// Bench for photon_bin_accumulator. Two instances (SUM_W=24 and SUM_W=4) share
// stimulus; an upstream click counter is modelled here and cleared by
// counter_reset. Expected bin sums are plain totals of the clicks injected
// during each bin's window, checked every cycle against both instances.
module tb_photon_bin_accumulator;

    localparam int BC    = 10;
    localparam int NB    = 4;
    localparam int IDX_W = 2;
    localparam int NITER = 2 + NB * BC + 10;
    localparam int MAX_A = 16777215;
    localparam int MAX_B = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       out_ready;
    logic [7:0] cnt;
    int         clicks;

    logic cr_a, busy_a, done_a, ovr_a;
    logic cr_b, busy_b, done_b, ovr_b;

    photon_bin_accumulator_if #(.SUM_W(24), .BIN_IDX_W(IDX_W)) bus_a ();
    photon_bin_accumulator_if #(.SUM_W(4),  .BIN_IDX_W(IDX_W)) bus_b ();

    assign bus_a.out_ready = out_ready;
    assign bus_b.out_ready = out_ready;

    photon_bin_accumulator #(
        .COUNT_W(8), .SUM_W(24), .BIN_CYCLES(BC), .NUM_BINS(NB)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .count_in(cnt),
        .counter_reset(cr_a), .busy(busy_a), .done(done_a), .overrun(ovr_a),
        .out_if(bus_a)
    );

    photon_bin_accumulator #(
        .COUNT_W(8), .SUM_W(4), .BIN_CYCLES(BC), .NUM_BINS(NB)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .count_in(cnt),
        .counter_reset(cr_b), .busy(busy_b), .done(done_b), .overrun(ovr_b),
        .out_if(bus_b)
    );

    always #5 clk = ~clk;

    // Upstream click counter: wraps modulo 256, cleared synchronously.
    always @(posedge clk) begin
        if (cr_a) cnt <= 8'd0;
        else      cnt <= cnt + 8'(clicks);
    end

    // Reference model state (after the most recent clock edge).
    bit m_valid, m_ovr, m_busy, m_done, m_cr, m_rst;
    int m_bin, m_sum;
    int c [0:63];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; clicks = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cr_a, busy_a, done_a, ovr_a, bus_a.out_valid} !== 5'b10000)
            $display("FAIL reset_ctl_a got %b want 10000", {cr_a, busy_a, done_a, ovr_a, bus_a.out_valid});
        else n_pass++;
        n_checks++;
        if ({cr_b, busy_b, done_b, ovr_b, bus_b.out_valid} !== 5'b10000)
            $display("FAIL reset_ctl_b got %b want 10000", {cr_b, busy_b, done_b, ovr_b, bus_b.out_valid});
        else n_pass++;
        n_checks++;
        if ({bus_a.out_bin, bus_a.out_sum, bus_a.out_sat} !== 27'd0)
            $display("FAIL reset_payload_a got %h want 0", {bus_a.out_bin, bus_a.out_sum, bus_a.out_sat});
        else n_pass++;
        n_checks++;
        if ({bus_b.out_bin, bus_b.out_sum, bus_b.out_sat} !== 7'd0)
            $display("FAIL reset_payload_b got %h want 0", {bus_b.out_bin, bus_b.out_sum, bus_b.out_sat});
        else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({cr_a, busy_a, done_a, ovr_a, bus_a.out_valid} !== 5'b00000)
                $display("FAIL idle_ctl_a k=%0d got %b want 00000", k, {cr_a, busy_a, done_a, ovr_a, bus_a.out_valid});
            else n_pass++;
            n_checks++;
            if ({cr_b, busy_b, done_b, ovr_b, bus_b.out_valid} !== 5'b00000)
                $display("FAIL idle_ctl_b k=%0d got %b want 00000", k, {cr_b, busy_b, done_b, ovr_b, bus_b.out_valid});
            else n_pass++;
        end
        m_valid = 0; m_ovr = 0; m_busy = 0; m_done = 0; m_cr = 0; m_rst = 0;
        m_bin = 0; m_sum = 0;
    endtask

    // click_mode: 0 constant click_val, 1 random, 2 rollover pattern
    // ready_mode: 0 always ready, 1 never ready, 2 random
    // abort_at:   clock edge index at which reset is pulsed (-1 for none)
    task automatic run_sweep(input string name, input int click_mode, input int click_val,
                             input int ready_mode, input int abort_at);
        bit aborted;
        bit hs;
        int b, s, ea, eb;
        logic [4:0] exp_ctl;
        aborted = 0;
        for (int i = 0; i <= NITER; i++) begin
            @(negedge clk);
            // Outputs now reflect clock edge i-1; compare with the model.
            exp_ctl = {m_cr, m_busy, m_done, m_ovr, m_valid};
            n_checks++;
            if ({cr_a, busy_a, done_a, ovr_a, bus_a.out_valid} !== exp_ctl)
                $display("FAIL %s ctl_a i=%0d got %b want %b", name, i,
                         {cr_a, busy_a, done_a, ovr_a, bus_a.out_valid}, exp_ctl);
            else n_pass++;
            n_checks++;
            if ({cr_b, busy_b, done_b, ovr_b, bus_b.out_valid} !== exp_ctl)
                $display("FAIL %s ctl_b i=%0d got %b want %b", name, i,
                         {cr_b, busy_b, done_b, ovr_b, bus_b.out_valid}, exp_ctl);
            else n_pass++;
            if (m_valid || m_rst) begin
                ea = (m_sum > MAX_A) ? MAX_A : m_sum;
                eb = (m_sum > MAX_B) ? MAX_B : m_sum;
                n_checks++;
                if ({bus_a.out_bin, bus_a.out_sum, bus_a.out_sat} !== {IDX_W'(m_bin), 24'(ea), m_sum > MAX_A})
                    $display("FAIL %s result_a i=%0d got bin=%0d sum=%0d sat=%b want bin=%0d sum=%0d sat=%b",
                             name, i, bus_a.out_bin, bus_a.out_sum, bus_a.out_sat, m_bin, ea, m_sum > MAX_A);
                else n_pass++;
                n_checks++;
                if ({bus_b.out_bin, bus_b.out_sum, bus_b.out_sat} !== {IDX_W'(m_bin), 4'(eb), m_sum > MAX_B})
                    $display("FAIL %s result_b i=%0d got bin=%0d sum=%0d sat=%b want bin=%0d sum=%0d sat=%b",
                             name, i, bus_b.out_bin, bus_b.out_sum, bus_b.out_sat, m_bin, eb, m_sum > MAX_B);
                else n_pass++;
            end

            // Drive inputs for clock edge i.
            start = (i == 0);
            reset = (i == abort_at);
            case (click_mode)
                0:       c[i] = click_val;
                1:       c[i] = int'($urandom_range(0, 255));
                default: c[i] = (i == 3) ? 250 : (i == 5) ? 10 : (i == 16) ? 240 : (i == 18) ? 20 : 0;
            endcase
            clicks = c[i];
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase

            // Model the effect of clock edge i.
            hs = m_valid && out_ready;
            if (i == abort_at) begin
                m_valid = 0; m_ovr = 0; m_busy = 0; m_done = 0; m_cr = 1; m_rst = 1;
                m_bin = 0; m_sum = 0;
                aborted = 1;
            end else begin
                m_rst = 0;
                if (hs) m_valid = 0;
                m_cr = 0; m_busy = 0; m_done = 0;
                if (!aborted) begin
                    m_cr   = (i == 0);
                    m_busy = (i <= 1 + NB * BC);
                    m_done = (i == 2 + NB * BC);
                    if (i == 0) m_ovr = 0;
                    // Bin b's sum covers clicks injected at edges 2+BC*b .. 1+BC*(b+1).
                    if (i >= 2 + BC && ((i - 2 - BC) % BC) == 0 && ((i - 2 - BC) / BC) < NB) begin
                        b = (i - 2 - BC) / BC;
                        s = 0;
                        for (int k = 2 + BC * b; k < 2 + BC * (b + 1); k++) s += c[k];
                        if (!m_valid) begin
                            m_valid = 1; m_bin = b; m_sum = s;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            end
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_constant_rate();
        run_sweep("const_rate", 0, 1, 0, -1);
    endtask

    task automatic test_wrap();
        run_sweep("wrap", 2, 0, 0, -1);
    endtask

    task automatic test_backpressure();
        run_sweep("backpressure", 0, 1, 1, -1);
        n_checks++;
        if ({bus_a.out_valid, bus_a.out_bin, bus_a.out_sum} !== {1'b1, 2'd0, 24'd10})
            $display("FAIL bp_held got valid=%b bin=%0d sum=%0d want valid=1 bin=0 sum=10",
                     bus_a.out_valid, bus_a.out_bin, bus_a.out_sum);
        else n_pass++;
        n_checks++;
        if (ovr_a !== 1'b1)
            $display("FAIL bp_overrun got %b want 1", ovr_a);
        else n_pass++;
        // Next sweep drains the stale bin-0 result and must clear overrun at start.
        run_sweep("bp_next_start", 0, 1, 0, -1);
        n_checks++;
        if (ovr_a !== 1'b0)
            $display("FAIL bp_overrun_cleared got %b want 0", ovr_a);
        else n_pass++;
    endtask

    task automatic test_saturation();
        run_sweep("saturation", 0, 2, 0, -1);
    endtask

    task automatic test_mid_sweep_reset();
        run_sweep("mid_reset", 1, 0, 2, 2 + 2 * BC + 3);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) run_sweep("random", 1, 0, 2, -1);
    endtask

    initial begin
        test_reset();
        test_constant_rate();
        test_wrap();
        test_backpressure();
        test_saturation();
        test_mid_sweep_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
